mem_wb_writeback_stage: RTL and testbench

- MEM/WB pipeline register and write-back select for the 5-stage CPU.
- Captures the MEM-stage result and produces the registered destination address, write enable and write data.
- These feed the register-file write-port decode tree, built from 2:4 decoders with enable.
- Also maintains a retired-instruction counter for debug and performance visibility.

---
 rtl/mem_wb_writeback_stage.sv | 73 +++++++
 tb/tb_mem_wb_writeback_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback_stage.sv
// MEM/WB pipeline register, write-back data select and retired-instruction counter.
// Optional macro FWD_CMP_EN adds WB->EX forwarding comparators (ex_src_a/b -> fwd_hit_a/b).
module mem_wb_writeback_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic                  wb_write_enable,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [CNT_WIDTH-1:0]  retired_count
`ifdef FWD_CMP_EN
  ,
  input  logic [ADDR_WIDTH-1:0] ex_src_a,
  input  logic [ADDR_WIDTH-1:0] ex_src_b,
  output logic                  fwd_hit_a,
  output logic                  fwd_hit_b
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  logic reg_write;
  logic advance;

  // The instruction in WB leaves it (retires) whenever the register is not held.
  assign advance = ~stall | flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      reg_write     <= 1'b0;
      retired_count <= '0;
    end else begin
      if (wb_valid && advance) begin
        retired_count <= retired_count + CNT_ONE;
      end
      if (flush) begin
        wb_valid  <= 1'b0;
        reg_write <= 1'b0;
      end else if (!stall) begin
        wb_valid  <= mem_valid;
        wb_rd     <= mem_rd;
        reg_write <= mem_reg_write & mem_valid;
        wb_data   <= mem_mem_to_reg ? mem_read_data : mem_alu_result;
      end
    end
  end

  // Registered state only, so the decoder tree sees a glitch-free enable.
  assign wb_write_enable = wb_valid & reg_write & (wb_rd != ZERO_ADDR);

`ifdef FWD_CMP_EN
  assign fwd_hit_a = wb_write_enable & (wb_rd == ex_src_a);
  assign fwd_hit_b = wb_write_enable & (wb_rd == ex_src_b);
`endif

endmodule

// File: tb/tb_mem_wb_writeback_stage.sv
// Directed bench for mem_wb_writeback_stage: scoreboard queue checked by a monitor,
// plus direct checks of reset, flush, stall hold and counter wrap (CNT_WIDTH=8).
module tb_mem_wb_writeback_stage;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int W  = 1 + AW + DW;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_to_reg;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_read_data;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          wb_write_enable;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] retired_count;
  logic [AW-1:0] ex_src_a;
  logic [AW-1:0] ex_src_b;
  logic          fwd_hit_a;
  logic          fwd_hit_b;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  logic cap_edge = 1'b0;
  logic hold_edge = 1'b0;

  mem_wb_writeback_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_write_enable(wb_write_enable), .wb_data(wb_data),
    .retired_count(retired_count)
`ifdef FWD_CMP_EN
    , .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b)
`endif
  );

`ifndef FWD_CMP_EN
  assign fwd_hit_a = 1'b0;
  assign fwd_hit_b = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: classify each edge, then compare on the following falling edge
  always @(posedge clk) begin
    cap_edge  = !reset && !flush && !stall;
    hold_edge = !reset && !flush && stall;
  end

  always @(negedge clk) begin
    if (cap_edge && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {wb_write_enable, wb_rd, wb_data}, '0);
      end else begin
        held = exp_q.pop_front();
        check("wb_capture", {wb_write_enable, wb_rd, wb_data}, held);
      end
    end else if (hold_edge && wb_valid === 1'b1) begin
      check("wb_stall_hold", {wb_write_enable, wb_rd, wb_data}, held);
    end
  end

  // driver tasks
  task automatic idle();
    mem_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic rw, input logic m2r,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                       input logic exp_we, input logic [DW-1:0] exp_data);
    mem_valid = 1'b1; mem_rd = rd; mem_reg_write = rw; mem_mem_to_reg = m2r;
    mem_alu_result = alu; mem_read_data = rdata; stall = 1'b0; flush = 1'b0;
    exp_q.push_back({exp_we, rd, exp_data});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_rd = '0;
    mem_reg_write = 1'b0; mem_mem_to_reg = 1'b0; mem_alu_result = '0;
    mem_read_data = '0; ex_src_a = '0; ex_src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("reset_valid", W'(wb_valid), W'(0));
    check("reset_we", W'(wb_write_enable), W'(0));
    check("reset_rd", W'(wb_rd), W'(0));
    check("reset_data", W'(wb_data), W'(0));
    check("reset_count", W'(retired_count), W'(0));

    // ALU result to x5
    issue(5'd5, 1'b1, 1'b0, 64'h1234, 64'h0, 1'b1, 64'h1234);
    check("count_before_retire", W'(retired_count), W'(0));
`ifdef FWD_CMP_EN
    ex_src_a = 5'd5; ex_src_b = 5'd6; #1;
    check("fwd_hit_a", W'(fwd_hit_a), W'(1));
    check("fwd_hit_b", W'(fwd_hit_b), W'(0));
`endif
    idle();
    check("count_first_retire", W'(retired_count), W'(1));

    // load to XZR: valid but write suppressed
    issue(5'd31, 1'b1, 1'b1, 64'h1234, 64'hDEAD, 1'b0, 64'hDEAD);
    check("xzr_valid", W'(wb_valid), W'(1));
`ifdef FWD_CMP_EN
    ex_src_a = 5'd31; #1;
    check("fwd_xzr_no_hit", W'(fwd_hit_a), W'(0));
`endif
    idle();
    check("count_xzr", W'(retired_count), W'(2));

    // capture x7 then stall three cycles with x9 waiting in MEM
    issue(5'd7, 1'b1, 1'b0, 64'h77, 64'h0, 1'b1, 64'h77);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_alu_result = 64'h99; stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("stall_rd", W'(wb_rd), W'(7));
    check("stall_we", W'(wb_write_enable), W'(1));
    check("count_during_stall", W'(retired_count), W'(2));
    idle();
    check("count_after_stall", W'(retired_count), W'(3));

    // flush and stall together with x4 valid in MEM
    issue(5'd3, 1'b1, 1'b0, 64'h33, 64'h0, 1'b1, 64'h33);
    mem_valid = 1'b1; mem_rd = 5'd4; mem_reg_write = 1'b1; mem_alu_result = 64'h44;
    stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", W'(wb_valid), W'(0));
    check("flush_we", W'(wb_write_enable), W'(0));
    check("count_flush", W'(retired_count), W'(4));
    idle();
    check("count_after_flush", W'(retired_count), W'(4));

    // reset asserted while stalled
    issue(5'd10, 1'b1, 1'b0, 64'hAA, 64'h0, 1'b1, 64'hAA);
    mem_valid = 1'b1; mem_rd = 5'd11; stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_stall_valid", W'(wb_valid), W'(0));
    check("rst_stall_we", W'(wb_write_enable), W'(0));
    check("rst_stall_rd", W'(wb_rd), W'(0));
    check("rst_stall_data", W'(wb_data), W'(0));
    check("rst_stall_count", W'(retired_count), W'(0));
    reset = 1'b0;
    idle();

    // 255 retirements reach all-ones, one more wraps to zero
    for (int i = 0; i < 255; i++) begin
      issue(AW'(i % 31), 1'b1, 1'b0, DW'(i), 64'h0, 1'b1, DW'(i));
    end
    idle();
    check("count_max", W'(retired_count), W'(8'hFF));
    issue(5'd2, 1'b1, 1'b0, 64'hF00D, 64'h0, 1'b1, 64'hF00D);
    idle();
    check("count_wrap", W'(retired_count), W'(0));

    idle();
    idle();
    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
